// File: rtl/id_ex_forward_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_forward_pkg
// Shared types and constants for the ID/EX forwarding boundary.
//   DATA_W, REG_AW : default operand and register-address widths
//   fwdSrc_t       : where a resolved operand came from
//   pipeState_t    : RUN / BUBBLE tracking state of the ID/EX register
//   isForwarded()  : true when an operand did not come straight from the RF
// -----------------------------------------------------------------------------
package id_ex_forward_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    FWD_RF   = 3'd0,
    FWD_EX   = 3'd1,
    FWD_MEM  = 3'd2,
    FWD_WB   = 3'd3,
    FWD_ZERO = 3'd4
  } fwdSrc_t;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } pipeState_t;

  // Register 0 reads as a hardwired zero, which is also not register-file data.
  function automatic logic isForwarded(input fwdSrc_t src);
    return (src != FWD_RF);
  endfunction

endpackage

// File: rtl/id_ex_forward_fwd_sel.sv
// -----------------------------------------------------------------------------
// id_ex_forward_fwd_sel
// Source selection and data mux for one ID-stage operand.
// Priority (highest first): register 0 -> zero, EX result, MEM write data,
// WB write data, register-file read data.
// Ports:
//   rR        source register number
//   rD        register-file read data for rR
//   exFwdEn   EX stage holds a live, non-load register writer
//   exWR      EX destination register
//   exResult  EX ALU result
//   memWe/memWR/memWD  MEM-stage write port
//   wbWe/wbWR/wbWD     WB-stage write port
//   opVal     resolved operand value
//   src       which source was chosen
// -----------------------------------------------------------------------------
module id_ex_forward_fwd_sel
  import id_ex_forward_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rR,
  input  logic [DATA_W-1:0] rD,
  input  logic              exFwdEn,
  input  logic [REG_AW-1:0] exWR,
  input  logic [DATA_W-1:0] exResult,
  input  logic              memWe,
  input  logic [REG_AW-1:0] memWR,
  input  logic [DATA_W-1:0] memWD,
  input  logic              wbWe,
  input  logic [REG_AW-1:0] wbWR,
  input  logic [DATA_W-1:0] wbWD,
  output logic [DATA_W-1:0] opVal,
  output fwdSrc_t           src
);

  always_comb begin
    src   = FWD_RF;
    opVal = rD;
    if (rR == '0) begin
      // r0 is never forwarded, even if some stage claims to write it.
      src   = FWD_ZERO;
      opVal = '0;
    end else if (exFwdEn && (exWR == rR)) begin
      // Youngest producer wins when several stages target the same register.
      src   = FWD_EX;
      opVal = exResult;
    end else if (memWe && (memWR == rR)) begin
      src   = FWD_MEM;
      opVal = memWD;
    end else if (wbWe && (wbWR == rR)) begin
      // The register file only writes at the edge, so the RF read in the same
      // cycle still returns the old value.
      src   = FWD_WB;
      opVal = wbWD;
    end
  end

endmodule

// File: rtl/id_ex_forward.sv
// -----------------------------------------------------------------------------
// id_ex_forward
// ID/EX pipeline register with operand forwarding and load-use stall.
// Sits directly downstream of the 32x32 register file. Operands are resolved
// combinationally in ID (forwarding from EX, MEM, WB) and registered at the
// rising edge; the ID->EX latency is one cycle. A load in EX whose destination
// is read by the ID instruction inserts a single-cycle bubble.
//
// Optional build macro:
//   HAZARD_CNT_EN  adds stall_cnt_o / fwd_cnt_o hazard counters.
//
// Ports:
//   clk_i, reset_i             clock, synchronous active-high reset
//   id_valid_i                 instruction present in ID
//   rR1_i, rR2_i, rD1_i, rD2_i source register numbers and RF read data
//   id_wR_i, id_we_i, id_load_i destination, write enable, load flag
//   id_imm_i, id_ctrl_i        immediate, opaque decoded control
//   flush_i                    taken branch/jump in EX, kill the ID instruction
//   ex_result_i                ALU result of the instruction in EX
//   mem_wR_i/we_i/wD_i         MEM-stage write port (load data included)
//   wb_wR_i/we_i/wD_i          WB-stage write port (drives the RF)
//   stall_o                    hold PC and IF/ID this cycle
//   ex_*_o                     ID/EX register contents for the ALU stage
//   stall_cnt_o, fwd_cnt_o     hazard counters (HAZARD_CNT_EN only)
// -----------------------------------------------------------------------------
module id_ex_forward
  import id_ex_forward_pkg::*;
#(
  parameter int DATA_W = id_ex_forward_pkg::DATA_W,
  parameter int REG_AW = id_ex_forward_pkg::REG_AW,
  parameter int CTRL_W = 12
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] rR1_i,
  input  logic [REG_AW-1:0] rR2_i,
  input  logic [DATA_W-1:0] rD1_i,
  input  logic [DATA_W-1:0] rD2_i,
  input  logic [REG_AW-1:0] id_wR_i,
  input  logic              id_we_i,
  input  logic              id_load_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] ex_result_i,
  input  logic [REG_AW-1:0] mem_wR_i,
  input  logic              mem_we_i,
  input  logic [DATA_W-1:0] mem_wD_i,
  input  logic [REG_AW-1:0] wb_wR_i,
  input  logic              wb_we_i,
  input  logic [DATA_W-1:0] wb_wD_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [DATA_W-1:0] ex_op1_o,
  output logic [DATA_W-1:0] ex_op2_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [REG_AW-1:0] ex_wR_o,
  output logic              ex_we_o,
  output logic              ex_load_o,
  output logic [CTRL_W-1:0] ex_ctrl_o
`ifdef HAZARD_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       fwd_cnt_o
`endif
);

  pipeState_t        stateReg;
  logic [REG_AW-1:0] rRsel  [2];
  logic [DATA_W-1:0] rDsel  [2];
  logic [DATA_W-1:0] opSel  [2];
  fwdSrc_t           srcSel [2];
  logic              exFwdEn;
  logic              loadUse;
  logic              killId;

  assign rRsel[0] = rR1_i;
  assign rRsel[1] = rR2_i;
  assign rDsel[0] = rD1_i;
  assign rDsel[1] = rD2_i;

  // A load in EX has no data yet; it is handled by the stall instead.
  assign exFwdEn = ex_valid_o & ex_we_o & ~ex_load_o;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      id_ex_forward_fwd_sel #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
      ) u_fwd_sel (
        .rR       (rRsel[gi]),
        .rD       (rDsel[gi]),
        .exFwdEn  (exFwdEn),
        .exWR     (ex_wR_o),
        .exResult (ex_result_i),
        .memWe    (mem_we_i),
        .memWR    (mem_wR_i),
        .memWD    (mem_wD_i),
        .wbWe     (wb_we_i),
        .wbWR     (wb_wR_i),
        .wbWD     (wb_wD_i),
        .opVal    (opSel[gi]),
        .src      (srcSel[gi])
      );
    end
  endgenerate

  // Both source fields are compared even if the instruction ignores one of
  // them; a spurious one-cycle stall is cheaper than decoding operand usage.
  assign loadUse = id_valid_i & ex_valid_o & ex_load_o & (ex_wR_o != '0) &
                   ((ex_wR_o == rR1_i) | (ex_wR_o == rR2_i));

  // In BUBBLE the register holds ex_valid_o=0, so loadUse is already low; the
  // state term just makes the one-cycle stall bound explicit.
  assign stall_o = loadUse & ~flush_i & (stateReg == RUN);

  // Flush overrides stall: either way the ID instruction does not enter EX.
  assign killId = flush_i | stall_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stateReg   <= RUN;
      ex_valid_o <= 1'b0;
      ex_we_o    <= 1'b0;
      ex_load_o  <= 1'b0;
      ex_op1_o   <= '0;
      ex_op2_o   <= '0;
      ex_imm_o   <= '0;
      ex_wR_o    <= '0;
      ex_ctrl_o  <= '0;
    end else begin
      // RUN->BUBBLE on stall, BUBBLE->RUN unconditionally (stall_o is low there).
      stateReg <= stall_o ? BUBBLE : RUN;

      // Data fields of a bubble are don't-care, so they are captured freely.
      ex_op1_o  <= opSel[0];
      ex_op2_o  <= opSel[1];
      ex_imm_o  <= id_imm_i;
      ex_wR_o   <= id_wR_i;
      ex_ctrl_o <= id_ctrl_i;

      if (killId) begin
        ex_valid_o <= 1'b0;
        ex_we_o    <= 1'b0;
        ex_load_o  <= 1'b0;
      end else begin
        ex_valid_o <= id_valid_i;
        ex_we_o    <= id_we_i;
        ex_load_o  <= id_load_i;
      end
    end
  end

`ifdef HAZARD_CNT_EN
  logic [31:0] stallCntReg;
  logic [31:0] fwdCntReg;
  logic        fwdCapture;

  // A live instruction is captured only when it is neither stalled nor flushed.
  assign fwdCapture = id_valid_i & ~killId &
                      (isForwarded(srcSel[0]) | isForwarded(srcSel[1]));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stallCntReg <= '0;
      fwdCntReg   <= '0;
    end else begin
      if (stall_o) begin
        stallCntReg <= stallCntReg + 32'd1;
      end
      if (fwdCapture) begin
        fwdCntReg <= fwdCntReg + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stallCntReg;
  assign fwd_cnt_o   = fwdCntReg;
`else
  // Operand sources only feed the hazard counters.
  logic unusedSrc;
  assign unusedSrc = ^{srcSel[0], srcSel[1]};
`endif

endmodule

// File: tb/tb_id_ex_forward.sv
module tb_id_ex_forward;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 12;
  localparam int BW = 3 + AW + 3 * DW + CW;

  localparam logic [BW-1:0] M_ALL = {BW{1'b1}};
  localparam logic [BW-1:0] M_BUB = {3'b111, {(BW - 3){1'b0}}};

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          id_valid_i = 1'b0;
  logic [AW-1:0] rR1_i = '0, rR2_i = '0, id_wR_i = '0;
  logic [DW-1:0] rD1_i = '0, rD2_i = '0, id_imm_i = '0;
  logic          id_we_i = 1'b0, id_load_i = 1'b0, flush_i = 1'b0;
  logic [CW-1:0] id_ctrl_i = '0;
  logic [DW-1:0] ex_result_i = '0, mem_wD_i = '0, wb_wD_i = '0;
  logic [AW-1:0] mem_wR_i = '0, wb_wR_i = '0;
  logic          mem_we_i = 1'b0, wb_we_i = 1'b0;

  logic          stall_o, ex_valid_o, ex_we_o, ex_load_o;
  logic [DW-1:0] ex_op1_o, ex_op2_o, ex_imm_o;
  logic [AW-1:0] ex_wR_o;
  logic [CW-1:0] ex_ctrl_o;
`ifdef HAZARD_CNT_EN
  logic [31:0]   stall_cnt_o, fwd_cnt_o;
`endif

  always #5 clk = ~clk;

  id_ex_forward #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .id_valid_i  (id_valid_i),
    .rR1_i       (rR1_i),
    .rR2_i       (rR2_i),
    .rD1_i       (rD1_i),
    .rD2_i       (rD2_i),
    .id_wR_i     (id_wR_i),
    .id_we_i     (id_we_i),
    .id_load_i   (id_load_i),
    .id_imm_i    (id_imm_i),
    .id_ctrl_i   (id_ctrl_i),
    .flush_i     (flush_i),
    .ex_result_i (ex_result_i),
    .mem_wR_i    (mem_wR_i),
    .mem_we_i    (mem_we_i),
    .mem_wD_i    (mem_wD_i),
    .wb_wR_i     (wb_wR_i),
    .wb_we_i     (wb_we_i),
    .wb_wD_i     (wb_wD_i),
    .stall_o     (stall_o),
    .ex_valid_o  (ex_valid_o),
    .ex_op1_o    (ex_op1_o),
    .ex_op2_o    (ex_op2_o),
    .ex_imm_o    (ex_imm_o),
    .ex_wR_o     (ex_wR_o),
    .ex_we_o     (ex_we_o),
    .ex_load_o   (ex_load_o),
    .ex_ctrl_o   (ex_ctrl_o)
`ifdef HAZARD_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .fwd_cnt_o   (fwd_cnt_o)
`endif
  );

  typedef struct {
    logic [BW-1:0] val;
    logic [BW-1:0] mask;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   failed = 0;

  function automatic logic [BW-1:0] ex_bus();
    return {ex_valid_o, ex_we_o, ex_load_o, ex_wR_o, ex_op1_o, ex_op2_o, ex_imm_o, ex_ctrl_o};
  endfunction

  function automatic logic [BW-1:0] mk(input logic v, input logic we, input logic ld,
                                       input logic [AW-1:0] wR, input logic [DW-1:0] o1,
                                       input logic [DW-1:0] o2, input logic [DW-1:0] imm,
                                       input logic [CW-1:0] ctrl);
    return {v, we, ld, wR, o1, o2, imm, ctrl};
  endfunction

  task automatic push_exp(input logic [BW-1:0] val, input logic [BW-1:0] mask);
    exp_t e;
    e.val  = val;
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] r1, input logic [DW-1:0] d1,
                        input logic [AW-1:0] r2, input logic [DW-1:0] d2,
                        input logic [AW-1:0] wR, input logic we, input logic ld,
                        input logic [DW-1:0] imm, input logic [CW-1:0] ctrl);
    id_valid_i = v;  rR1_i = r1;  rD1_i = d1;  rR2_i = r2;  rD2_i = d2;
    id_wR_i = wR;    id_we_i = we; id_load_i = ld; id_imm_i = imm; id_ctrl_i = ctrl;
  endtask

  task automatic set_fwd(input logic [DW-1:0] exr, input logic mwe, input logic [AW-1:0] mwr,
                         input logic [DW-1:0] mwd, input logic wwe, input logic [AW-1:0] wwr,
                         input logic [DW-1:0] wwd);
    ex_result_i = exr;
    mem_we_i = mwe; mem_wR_i = mwr; mem_wD_i = mwd;
    wb_we_i = wwe;  wb_wR_i = wwr;  wb_wD_i = wwd;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      reset_i = (c == 0);
      if (c == 0) set_id(1'b1, 5'd3, 32'h11, 5'd4, 32'h22, 5'd9, 1'b1, 1'b1, 32'hABC, 12'hFFF);
      else        set_id(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 12'h0);
      push_exp('0, M_ALL);
      tick();
      tests++;
      if (stall_o !== 1'b0) begin
        failed++;
        $display("FAIL reset stall cyc%0d: got %b, expected 0", c, stall_o);
      end
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL reset cyc%0d: scoreboard empty", c);
      end else begin
        e = sb.pop_front();
        if ((ex_bus() & e.mask) !== (e.val & e.mask)) begin
          failed++;
          $display("FAIL reset cyc%0d: got %h, expected %h", c, ex_bus() & e.mask, e.val & e.mask);
        end
      end
      $display("[TB] reset cyc%0d: bus=%h", c, ex_bus());
    end
  endtask

  task automatic test_no_hazard();
    exp_t e;
    set_fwd(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_id(1'b1, 5'd3, 32'h11, 5'd4, 32'h22, 5'd9, 1'b1, 1'b0, 32'h100, 12'h05A);
    push_exp(mk(1'b1, 1'b1, 1'b0, 5'd9, 32'h11, 32'h22, 32'h100, 12'h05A), M_ALL);
    #1;
    tests++;
    if (stall_o !== 1'b0) begin
      failed++;
      $display("FAIL no_hazard stall: got %b, expected 0", stall_o);
    end
    tick();
    tests++;
    if (sb.size() == 0) begin
      failed++;
      $display("FAIL no_hazard: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ((ex_bus() & e.mask) !== (e.val & e.mask)) begin
        failed++;
        $display("FAIL no_hazard: got %h, expected %h", ex_bus() & e.mask, e.val & e.mask);
      end
    end
    $display("[TB] no_hazard: op1=%h op2=%h", ex_op1_o, ex_op2_o);
  endtask

  task automatic test_ex_forward();
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      case (c)
        0: begin
          set_fwd(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
          set_id(1'b1, 5'd1, 32'h1, 5'd2, 32'h2, 5'd5, 1'b1, 1'b0, 32'h0, 12'h001);
          push_exp(mk(1'b1, 1'b1, 1'b0, 5'd5, 32'h1, 32'h2, 32'h0, 12'h001), M_ALL);
        end
        default: begin
          set_fwd(32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
          set_id(1'b1, 5'd5, 32'hDEAD, 5'd6, 32'h66, 5'd10, 1'b1, 1'b0, 32'h4, 12'h002);
          push_exp(mk(1'b1, 1'b1, 1'b0, 5'd10, 32'h1234, 32'h66, 32'h4, 12'h002), M_ALL);
        end
      endcase
      #1;
      tests++;
      if (stall_o !== 1'b0) begin
        failed++;
        $display("FAIL ex_forward stall cyc%0d: got %b, expected 0", c, stall_o);
      end
      tick();
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL ex_forward cyc%0d: scoreboard empty", c);
      end else begin
        e = sb.pop_front();
        if ((ex_bus() & e.mask) !== (e.val & e.mask)) begin
          failed++;
          $display("FAIL ex_forward cyc%0d: got %h, expected %h", c, ex_bus() & e.mask, e.val & e.mask);
        end
      end
      $display("[TB] ex_forward cyc%0d: op1=%h op2=%h", c, ex_op1_o, ex_op2_o);
    end
  endtask

  task automatic test_priority();
    exp_t e;
    logic es;
    for (int c = 0; c < 4; c++) begin
      es = 1'b0;
      case (c)
        0: begin
          set_fwd(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
          set_id(1'b1, 5'd1, 32'h1, 5'd2, 32'h2, 5'd7, 1'b1, 1'b0, 32'h0, 12'h010);
          push_exp(mk(1'b1, 1'b1, 1'b0, 5'd7, 32'h1, 32'h2, 32'h0, 12'h010), M_ALL);
        end
        1: begin
          // r7 matches EX (non-load), MEM and WB: EX wins. This one is a load of r7.
          set_fwd(32'hA, 1'b1, 5'd7, 32'hB, 1'b1, 5'd7, 32'hC);
          set_id(1'b1, 5'd7, 32'h77, 5'd7, 32'h77, 5'd7, 1'b1, 1'b1, 32'h8, 12'h011);
          push_exp(mk(1'b1, 1'b1, 1'b1, 5'd7, 32'hA, 32'hA, 32'h8, 12'h011), M_ALL);
        end
        2: begin
          // Same matches but EX is now a load: stall, bubble.
          set_id(1'b1, 5'd7, 32'h77, 5'd7, 32'h77, 5'd12, 1'b1, 1'b0, 32'h9, 12'h012);
          push_exp('0, M_BUB);
          es = 1'b1;
        end
        default: begin
          // EX empty: MEM beats WB.
          push_exp(mk(1'b1, 1'b1, 1'b0, 5'd12, 32'hB, 32'hB, 32'h9, 12'h012), M_ALL);
        end
      endcase
      #1;
      tests++;
      if (stall_o !== es) begin
        failed++;
        $display("FAIL priority stall cyc%0d: got %b, expected %b", c, stall_o, es);
      end
      tick();
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL priority cyc%0d: scoreboard empty", c);
      end else begin
        e = sb.pop_front();
        if ((ex_bus() & e.mask) !== (e.val & e.mask)) begin
          failed++;
          $display("FAIL priority cyc%0d: got %h, expected %h", c, ex_bus() & e.mask, e.val & e.mask);
        end
      end
      $display("[TB] priority cyc%0d: stall=%b valid=%b op1=%h op2=%h", c, es, ex_valid_o, ex_op1_o, ex_op2_o);
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    logic es;
    for (int c = 0; c < 3; c++) begin
      es = 1'b0;
      case (c)
        0: begin
          set_fwd(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
          set_id(1'b1, 5'd1, 32'h1, 5'd2, 32'h2, 5'd8, 1'b1, 1'b1, 32'h0, 12'h020);
          push_exp(mk(1'b1, 1'b1, 1'b1, 5'd8, 32'h1, 32'h2, 32'h0, 12'h020), M_ALL);
        end
        1: begin
          set_id(1'b1, 5'd8, 32'hBAD, 5'd3, 32'h33, 5'd13, 1'b1, 1'b0, 32'h3, 12'h021);
          push_exp('0, M_BUB);
          es = 1'b1;
        end
        default: begin
          set_fwd(32'h0, 1'b1, 5'd8, 32'h55, 1'b0, 5'd0, 32'h0);
          push_exp(mk(1'b1, 1'b1, 1'b0, 5'd13, 32'h55, 32'h33, 32'h3, 12'h021), M_ALL);
        end
      endcase
      #1;
      tests++;
      if (stall_o !== es) begin
        failed++;
        $display("FAIL load_use stall cyc%0d: got %b, expected %b", c, stall_o, es);
      end
      tick();
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL load_use cyc%0d: scoreboard empty", c);
      end else begin
        e = sb.pop_front();
        if ((ex_bus() & e.mask) !== (e.val & e.mask)) begin
          failed++;
          $display("FAIL load_use cyc%0d: got %h, expected %h", c, ex_bus() & e.mask, e.val & e.mask);
        end
      end
      $display("[TB] load_use cyc%0d: stall=%b valid=%b op1=%h", c, es, ex_valid_o, ex_op1_o);
    end
    set_fwd(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_reg_zero();
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin
          // Load to r0 in EX must not stall a reader of r0.
          set_fwd(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
          set_id(1'b1, 5'd1, 32'h1, 5'd2, 32'h2, 5'd0, 1'b1, 1'b1, 32'h0, 12'h030);
          push_exp(mk(1'b1, 1'b1, 1'b1, 5'd0, 32'h1, 32'h2, 32'h0, 12'h030), M_ALL);
        end
        1: begin
          set_fwd(32'hFFFF, 1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hFFFF);
          set_id(1'b1, 5'd0, 32'hFFFF, 5'd0, 32'hFFFF, 5'd0, 1'b1, 1'b0, 32'h5, 12'h031);
          push_exp(mk(1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 32'h5, 12'h031), M_ALL);
        end
        default: begin
          // Now a non-load r0 writer sits in EX as well.
          set_id(1'b1, 5'd0, 32'hFFFF, 5'd0, 32'hFFFF, 5'd14, 1'b1, 1'b0, 32'h6, 12'h032);
          push_exp(mk(1'b1, 1'b1, 1'b0, 5'd14, 32'h0, 32'h0, 32'h6, 12'h032), M_ALL);
        end
      endcase
      #1;
      tests++;
      if (stall_o !== 1'b0) begin
        failed++;
        $display("FAIL reg_zero stall cyc%0d: got %b, expected 0", c, stall_o);
      end
      tick();
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL reg_zero cyc%0d: scoreboard empty", c);
      end else begin
        e = sb.pop_front();
        if ((ex_bus() & e.mask) !== (e.val & e.mask)) begin
          failed++;
          $display("FAIL reg_zero cyc%0d: got %h, expected %h", c, ex_bus() & e.mask, e.val & e.mask);
        end
      end
      $display("[TB] reg_zero cyc%0d: op1=%h op2=%h", c, ex_op1_o, ex_op2_o);
    end
    set_fwd(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [DW-1:0] o1;
    for (int c = 0; c < 4; c++) begin
      // Each instruction reads the previous one's destination.
      set_fwd(32'h100 + 32'(c), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      set_id(1'b1, (c == 0) ? 5'd1 : 5'(19 + c), 32'h999, 5'd2, 32'h2, 5'(20 + c),
             1'b1, 1'b0, 32'(c), 12'h040 + 12'(c));
      o1 = (c == 0) ? 32'h999 : 32'h100 + 32'(c);
      push_exp(mk(1'b1, 1'b1, 1'b0, 5'(20 + c), o1, 32'h2, 32'(c), 12'h040 + 12'(c)), M_ALL);
      #1;
      tests++;
      if (stall_o !== 1'b0) begin
        failed++;
        $display("FAIL back_to_back stall cyc%0d: got %b, expected 0", c, stall_o);
      end
      tick();
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL back_to_back cyc%0d: scoreboard empty", c);
      end else begin
        e = sb.pop_front();
        if ((ex_bus() & e.mask) !== (e.val & e.mask)) begin
          failed++;
          $display("FAIL back_to_back cyc%0d: got %h, expected %h", c, ex_bus() & e.mask, e.val & e.mask);
        end
      end
      $display("[TB] back_to_back cyc%0d: op1=%h", c, ex_op1_o);
    end
    set_fwd(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_flush();
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin
          set_id(1'b1, 5'd1, 32'h1, 5'd2, 32'h2, 5'd9, 1'b1, 1'b1, 32'h0, 12'h050);
          push_exp(mk(1'b1, 1'b1, 1'b1, 5'd9, 32'h1, 32'h2, 32'h0, 12'h050), M_ALL);
        end
        1: begin
          // Load-use and flush together: flush wins, no stall, bubble.
          flush_i = 1'b1;
          set_id(1'b1, 5'd9, 32'h9, 5'd3, 32'h3, 5'd15, 1'b1, 1'b0, 32'h0, 12'h051);
          push_exp('0, M_BUB);
        end
        default: begin
          flush_i = 1'b0;
          set_id(1'b1, 5'd4, 32'h4, 5'd5, 32'h5, 5'd16, 1'b1, 1'b0, 32'h0, 12'h052);
          push_exp(mk(1'b1, 1'b1, 1'b0, 5'd16, 32'h4, 32'h5, 32'h0, 12'h052), M_ALL);
        end
      endcase
      #1;
      tests++;
      if (stall_o !== 1'b0) begin
        failed++;
        $display("FAIL flush stall cyc%0d: got %b, expected 0", c, stall_o);
      end
      tick();
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL flush cyc%0d: scoreboard empty", c);
      end else begin
        e = sb.pop_front();
        if ((ex_bus() & e.mask) !== (e.val & e.mask)) begin
          failed++;
          $display("FAIL flush cyc%0d: got %h, expected %h", c, ex_bus() & e.mask, e.val & e.mask);
        end
      end
      $display("[TB] flush cyc%0d: valid=%b", c, ex_valid_o);
    end
  endtask

  task automatic test_reset_bubble();
    exp_t e;
    logic es;
    for (int c = 0; c < 6; c++) begin
      es = 1'b0;
      case (c)
        0: begin
          set_id(1'b1, 5'd1, 32'h1, 5'd2, 32'h2, 5'd4, 1'b1, 1'b1, 32'h0, 12'h060);
          push_exp(mk(1'b1, 1'b1, 1'b1, 5'd4, 32'h1, 32'h2, 32'h0, 12'h060), M_ALL);
        end
        1: begin
          // Load-use through the second operand.
          set_id(1'b1, 5'd3, 32'h3, 5'd4, 32'h44, 5'd17, 1'b1, 1'b0, 32'h7, 12'h061);
          push_exp('0, M_BUB);
          es = 1'b1;
        end
        2: begin
          // Reset while in BUBBLE: everything returns to zero.
          reset_i = 1'b1;
          push_exp('0, M_ALL);
        end
        3: begin
          reset_i = 1'b0;
          set_id(1'b1, 5'd1, 32'h1, 5'd2, 32'h2, 5'd4, 1'b1, 1'b1, 32'h0, 12'h062);
          push_exp(mk(1'b1, 1'b1, 1'b1, 5'd4, 32'h1, 32'h2, 32'h0, 12'h062), M_ALL);
        end
        4: begin
          set_id(1'b1, 5'd4, 32'h44, 5'd5, 32'h5, 5'd18, 1'b1, 1'b0, 32'h0, 12'h063);
          push_exp('0, M_BUB);
          es = 1'b1;
        end
        default: begin
          set_fwd(32'h0, 1'b1, 5'd4, 32'h66, 1'b0, 5'd0, 32'h0);
          push_exp(mk(1'b1, 1'b1, 1'b0, 5'd18, 32'h66, 32'h5, 32'h0, 12'h063), M_ALL);
        end
      endcase
      #1;
      tests++;
      if (stall_o !== es) begin
        failed++;
        $display("FAIL reset_bubble stall cyc%0d: got %b, expected %b", c, stall_o, es);
      end
      tick();
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL reset_bubble cyc%0d: scoreboard empty", c);
      end else begin
        e = sb.pop_front();
        if ((ex_bus() & e.mask) !== (e.val & e.mask)) begin
          failed++;
          $display("FAIL reset_bubble cyc%0d: got %h, expected %h", c, ex_bus() & e.mask, e.val & e.mask);
        end
      end
      $display("[TB] reset_bubble cyc%0d: stall=%b valid=%b op1=%h", c, es, ex_valid_o, ex_op1_o);
    end
    set_fwd(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_no_hazard();
    test_ex_forward();
    test_priority();
    test_load_use();
    test_reg_zero();
    test_back_to_back();
    test_flush();
    test_reset_bubble();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/id_ex_forward.md
# id_ex_forward

Decode-to-execute boundary of the forwarding pipeline; sits directly downstream of the 32×32 register file.
- Takes the two register-file read values plus the decoded instruction fields.
- Resolves data hazards by forwarding from the EX, MEM and WB stages, or by stalling one cycle on load-use.
- Registers the resolved operands into the ID/EX pipeline register consumed by the ALU stage.

## Interface
Parameters:
- DATA_W, 32, operand/data width
- REG_AW, 5, register address width
- CTRL_W, 12, opaque decoded-control bundle width

Ports:
- clk_i  in  1  single clock; all state updates on rising edge
- reset_i  in  1  reset, synchronous, active-high
- id_valid_i  in  1  instruction present in ID
- rR1_i, rR2_i  in  REG_AW  source register numbers (same values driven to register file)
- rD1_i, rD2_i  in  DATA_W  register-file read data
- id_wR_i  in  REG_AW  destination register
- id_we_i  in  1  instruction writes a register
- id_load_i  in  1  instruction is a load
- id_imm_i  in  DATA_W  extended immediate
- id_ctrl_i  in  CTRL_W  decoded control
- flush_i  in  1  taken branch/jump resolved in EX; kill ID instruction
- ex_result_i  in  DATA_W  ALU result of instruction currently in EX
- mem_wR_i, mem_we_i, mem_wD_i  in  REG_AW/1/DATA_W  MEM-stage destination, write enable, final write data (load data included)
- wb_wR_i, wb_we_i, wb_wD_i  in  REG_AW/1/DATA_W  WB-stage write port (same signals that drive the register file)
- stall_o  out  1  hold PC and IF/ID this cycle
- ex_valid_o  out  1  ID/EX holds a live instruction
- ex_op1_o, ex_op2_o  out  DATA_W  resolved operands
- ex_imm_o  out  DATA_W  immediate
- ex_wR_o  out  REG_AW  destination
- ex_we_o, ex_load_o  out  1  write enable, load flag
- ex_ctrl_o  out  CTRL_W  control

## Operation
- Operand source select per operand, highest priority first:
  - reg number 0 → 0, never forwarded.
  - EX match → ex_result_i. Match: ex_valid_o & ex_we_o & !ex_load_o & ex_wR_o==rRn.
  - MEM match → mem_wD_i. Match: mem_we_i & mem_wR_i==rRn.
  - WB match → wb_wD_i. WB forwarding is required because the register file writes only at the clock edge.
  - Otherwise → rDn_i.
- Load-use: a stall is needed when id_valid_i & ex_valid_o & ex_load_o & ex_wR_o!=0 & (ex_wR_o==rR1_i | ex_wR_o==rR2_i). Both operands are compared regardless of whether the instruction uses them.
- stall_o = load-use condition & !flush_i.
- On stall, the ID/EX register loads a bubble: ex_valid_o=0, ex_we_o=0, ex_load_o=0, other fields don't-care.
- On the next cycle the load has moved to MEM and is forwarded from mem_wD_i.
- On flush_i, a bubble is loaded. Flush overrides stall.
- Otherwise the register captures id_valid_i and the resolved fields.
- Two-state FSM, RUN/BUBBLE, used for tracking and checking only:
  - RUN→BUBBLE on stall.
  - BUBBLE→RUN unconditionally.
  - stall_o is never asserted in BUBBLE: the condition cannot recur because ex_valid_o=0.

## Timing
- Operand resolution is combinational in ID; operands are registered at the edge; latency is 1 cycle ID→EX.
- Reset, and first edge after reset: ex_valid_o=0, ex_we_o=0, ex_load_o=0, ex_op1_o=ex_op2_o=ex_imm_o=0, ex_wR_o=0, ex_ctrl_o=0, FSM=RUN, stall_o=0.
- stall_o is combinational and valid in the same cycle as the ID inputs. Maximum stall length is 1 cycle.
- Simultaneous EX/MEM/WB matches on the same register: the youngest (EX) wins.
- Reset asserted mid-stall: the bubble is discarded and the FSM returns to RUN.

## Configuration
- HAZARD_CNT_EN defined: adds two 32-bit outputs.
  - stall_cnt_o: increments on each cycle stall_o=1.
  - fwd_cnt_o: increments on each captured live instruction with at least one non-RF operand source.
  - Both cleared by reset_i and wrap modulo 2^32.
- HAZARD_CNT_EN undefined: the ports and counters are absent.

## Structure
- Shared package holds the forwarding-source enum (FWD_RF, FWD_EX, FWD_MEM, FWD_WB, FWD_ZERO), the RUN/BUBBLE state enum, and the DATA_W/REG_AW constants.
- One sub-module, fwd_sel: source-select priority logic plus data mux for one operand. It is instantiated twice.

## Test plan
- No hazard: rR1=3 (rD1=0x11), rR2=4 (rD2=0x22), no matches → next cycle ex_op1_o=0x11, ex_op2_o=0x22, stall_o=0.
- EX forward: ADD r5 in EX, ex_result_i=0x1234; ID reads r5 with rD1=0xDEAD → ex_op1_o=0x1234.
- Priority: r7 matched in EX (0xA), MEM (0xB) and WB (0xC) → operand 0xA. Same case with EX as a load → stall_o=1.
- Load-use: LW r8 in EX, ID reads r8 → stall_o=1 for exactly one cycle and bubble in EX. Next cycle mem_wD_i=0x55 → ex_op1_o=0x55.
- Register 0: all stages target r0 with data 0xFFFF, ID reads r0 → operand 0, no stall.
- Flush plus load-use in the same cycle → stall_o=0 and ex_valid_o=0 next cycle. Reset during BUBBLE → all outputs 0 next edge.
